periph_req_arbiter: RTL

PERIPH_REQ_ARBITER -- requirements
Module: periph_req_arbiter

---
 rtl/periph_req_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/periph_req_arbiter.sv
// Round-robin arbiter funnelling NumReq upstream requesters onto one peripheral port.
// Optional WAIT timeout with stale-response drop is enabled by defining PERIPH_ARB_TIMEOUT_EN.
module periph_req_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0][63:0]  addr_i,
  input  logic [NumReq-1:0]        we_i,
  input  logic [NumReq-1:0][63:0]  wdata_i,
  input  logic [NumReq-1:0][7:0]   be_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [63:0]              rdata_o,
  output logic                     err_o,
  output logic                     req_o,
  output logic [63:0]              addr_o,
  output logic                     we_o,
  output logic [63:0]              wdata_o,
  output logic [7:0]               be_o,
  output logic [3:0]               tgt_o,
  input  logic                     gnt_i,
  input  logic                     rvalid_i,
  input  logic [63:0]              rdata_i,
  input  logic                     err_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  // IDLE arbitrate | ISSUE downstream req | WAIT for rvalid | RESP upstream rvalid | DECERR unmapped
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DECERR} state_e;

  state_e             r_state;
  logic [IdxW-1:0]    r_ptr;
  logic [IdxW-1:0]    r_win;
  logic [63:0]        r_addr;
  logic               r_we;
  logic [63:0]        r_wdata;
  logic [7:0]         r_be;
  logic [3:0]         r_tgt;
  logic               r_req;
  logic [NumReq-1:0]  r_rvalid;
  logic [63:0]        r_rdata;
  logic               r_err;

  logic [IdxW-1:0]    w_win;
  logic               w_any;
  logic               w_grant;
  logic               w_blocked;
  logic [4:0]         w_dec;
  logic [NumReq-1:0]  w_resp_oh;

`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam logic [7:0] CntLoad = 8'(TimeoutCycles - 1);
  logic [7:0] r_cnt;
  logic       r_stale;
  assign w_blocked = r_stale;
`else
  assign w_blocked = 1'b0;
`endif

  function automatic logic in_rng(input logic [63:0] a, input logic [63:0] base,
                                  input logic [63:0] len);
    return (a >= base) && (a < base + len);
  endfunction

  // Returns {hit, target}; DRAM and holes are misses and never go downstream.
  function automatic logic [4:0] decode(input logic [63:0] a);
    logic [4:0] d;
    d = 5'd0;
    if      (in_rng(a, 64'h0000_0000, 64'h0000_1000)) d = {1'b1, 4'd10};
    else if (in_rng(a, 64'h0001_0000, 64'h0001_0000)) d = {1'b1, 4'd9};
    else if (in_rng(a, 64'h0200_0000, 64'h000C_0000)) d = {1'b1, 4'd8};
    else if (in_rng(a, 64'h0C00_0000, 64'h03FF_FFFF)) d = {1'b1, 4'd7};
    else if (in_rng(a, 64'h1000_0000, 64'h0000_1000)) d = {1'b1, 4'd6};
    else if (in_rng(a, 64'h1800_0000, 64'h0000_1000)) d = {1'b1, 4'd5};
    else if (in_rng(a, 64'h2000_0000, 64'h0080_0000)) d = {1'b1, 4'd4};
    else if (in_rng(a, 64'h3000_0000, 64'h0001_0000)) d = {1'b1, 4'd3};
    else if (in_rng(a, 64'h4000_0000, 64'h0000_1000)) d = {1'b1, 4'd2};
    else if (in_rng(a, 64'h5000_0000, 64'h03FF_FFFF)) d = {1'b1, 4'd0};
    return d;
  endfunction

  always_comb begin
    int unsigned idx;
    idx   = 0;
    w_win = r_ptr;
    w_any = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!w_any && req_i[IdxW'(idx)]) begin
        w_any = 1'b1;
        w_win = IdxW'(idx);
      end
    end
  end

  assign w_grant   = (r_state == S_IDLE) && w_any && !w_blocked && !rst_i;
  assign gnt_o     = w_grant ? (NumReq'(1) << w_win) : '0;
  assign w_dec     = decode(addr_i[w_win]);
  assign w_resp_oh = NumReq'(1) << r_win;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_tgt    <= '0;
      r_req    <= 1'b0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
`ifdef PERIPH_ARB_TIMEOUT_EN
      r_cnt    <= '0;
      r_stale  <= 1'b0;
`endif
    end else begin
`ifdef PERIPH_ARB_TIMEOUT_EN
      // The late response of a timed-out transaction is swallowed here.
      if (r_stale && rvalid_i) r_stale <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_win   <= w_win;
            r_addr  <= addr_i[w_win];
            r_we    <= we_i[w_win];
            r_wdata <= wdata_i[w_win];
            r_be    <= be_i[w_win];
            r_tgt   <= w_dec[3:0];
            r_ptr   <= (w_win == IdxW'(NumReq - 1)) ? '0 : w_win + 1'b1;
            if (w_dec[4]) begin
              r_req   <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_DECERR;
            end
          end
        end
        S_ISSUE: begin
          if (gnt_i) begin
            r_req <= 1'b0;
            if (rvalid_i) begin
              r_rvalid <= w_resp_oh;
              r_rdata  <= rdata_i;
              r_err    <= err_i;
              r_state  <= S_RESP;
            end else begin
              r_state <= S_WAIT;
`ifdef PERIPH_ARB_TIMEOUT_EN
              r_cnt   <= CntLoad;
`endif
            end
          end
        end
        S_WAIT: begin
          if (rvalid_i) begin
            r_rvalid <= w_resp_oh;
            r_rdata  <= rdata_i;
            r_err    <= err_i;
            r_state  <= S_RESP;
          end
`ifdef PERIPH_ARB_TIMEOUT_EN
          else if (r_cnt == 8'd0) begin
            r_rvalid <= w_resp_oh;
            r_rdata  <= '0;
            r_err    <= 1'b1;
            r_stale  <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
`endif
        end
        S_DECERR: begin
          r_rvalid <= w_resp_oh;
          r_rdata  <= '0;
          r_err    <= 1'b1;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          r_rvalid <= '0;
          r_rdata  <= '0;
          r_err    <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
  assign req_o    = r_req;
  assign addr_o   = r_addr;
  assign we_o     = r_we;
  assign wdata_o  = r_wdata;
  assign be_o     = r_be;
  assign tgt_o    = r_tgt;

endmodule
